// File: rtl/ldpc_serial_encoder.sv
// Bit-serial LDPC encoder: one generator column per clock, codeword built MSB-first by left shift.
// Optional build macro LDPC_ENC_SYSTEMATIC_EN: info word loaded as codeword MSBs, only parity columns K..N-1 computed.
module ldpc_serial_encoder #(
  parameter int N = 11,
  parameter int K = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [K-1:0]         info_bits,
  input  logic                 g_we,
  input  logic [$clog2(N)-1:0] g_addr,
  input  logic [K-1:0]         g_wdata,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [N-1:0]         codeword
);

  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [K-1:0]  info_q;
  logic [N-1:0]  cw_q;
  logic [N-1:0]  cw_d;
  logic [K-1:0]  g_q [N];
  logic          ready_q;
  logic          valid_q;
  logic          par_bit;

  // Parity of the current column shifts in at the LSB; systematic builds keep the info MSBs fixed.
  always_comb begin
    par_bit = ^(info_q & g_q[cnt_q]);
    cw_d    = {cw_q[N-2:0], par_bit};
`ifdef LDPC_ENC_SYSTEMATIC_EN
    cw_d[N-1:N-K] = cw_q[N-1:N-K];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      info_q  <= '0;
      cw_q    <= '0;
      for (int i = 0; i < N; i++) begin
        g_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (g_we && (g_addr <= LAST)) begin
            g_q[g_addr] <= g_wdata;
          end
          if (i_valid) begin
            info_q  <= info_bits;
`ifdef LDPC_ENC_SYSTEMATIC_EN
            cnt_q   <= AW'(K);
            cw_q    <= {info_bits, {(N-K){1'b0}}};
`else
            cnt_q   <= '0;
            cw_q    <= '0;
`endif
            state_q <= ENCODE;
            ready_q <= 1'b0;
          end
        end
        ENCODE: begin
          cw_q  <= cw_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: begin
          // Leaving DONE lands in IDLE, so a new word can only be taken one edge later.
          if (o_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign i_ready  = ready_q;
  assign o_valid  = valid_q;
  assign codeword = cw_q;

endmodule
